stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer_if.sv | 64 ++++++
 rtl/stage_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// -----------------------------------------------------------------------------
// stage_sequencer_if
//
// Purpose : groups the control/status signals between the instruction-cycle
//           sequencer and the datapath/memory side of a small CPU.
//
// Signals :
//   INSTRUCTION [15:0]  IR contents, examined by the sequencer in DECODE
//   MEM_READY           memory read data valid (only meaningful in FETCH)
//   STAGE       [1:0]   current sequencer state (FETCH/DECODE/EXECUTE/WRITEBACK)
//   MEM_EN              memory read request
//   MAR_LE              MAR load pulse
//   IR_LE               IR load pulse
//   PC_LE               PC increment/load pulse
//   ALU_BUSY            ALU operation in progress
//   RD_LE               destination register write pulse
//   ILLEGAL             one-cycle flag for an unsupported instruction
//   INSTR_COUNT [15:0]  retired-instruction counter
//
// Modports:
//   master : the sequencer (drives control/status, reads IR and MEM_READY)
//   slave  : the datapath/memory side (drives IR and MEM_READY)
// -----------------------------------------------------------------------------
interface stage_sequencer_if;
    logic [15:0] INSTRUCTION;
    logic        MEM_READY;
    logic [1:0]  STAGE;
    logic        MEM_EN;
    logic        MAR_LE;
    logic        IR_LE;
    logic        PC_LE;
    logic        ALU_BUSY;
    logic        RD_LE;
    logic        ILLEGAL;
    logic [15:0] INSTR_COUNT;

    modport master (
        input  INSTRUCTION,
        input  MEM_READY,
        output STAGE,
        output MEM_EN,
        output MAR_LE,
        output IR_LE,
        output PC_LE,
        output ALU_BUSY,
        output RD_LE,
        output ILLEGAL,
        output INSTR_COUNT
    );

    modport slave (
        output INSTRUCTION,
        output MEM_READY,
        input  STAGE,
        input  MEM_EN,
        input  MAR_LE,
        input  IR_LE,
        input  PC_LE,
        input  ALU_BUSY,
        input  RD_LE,
        input  ILLEGAL,
        input  INSTR_COUNT
    );
endinterface

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose : four-stage instruction-cycle controller
//           FETCH -> DECODE -> EXECUTE (1 or 4 cycles) -> WRITEBACK -> FETCH.
//           FETCH waits for MEM_READY; DECODE classifies the opcode and either
//           launches EXECUTE or flags ILLEGAL and returns to FETCH; WRITEBACK
//           writes the destination register and counts the retired instruction.
//
// Ports   :
//   CLK      input   clock, all state changes on the rising edge
//   RESET_N  input   synchronous active-low reset; while low every 1-bit
//                    control output is forced to 0
//   bus      master  stage_sequencer_if (see that file for signal list)
// -----------------------------------------------------------------------------
module stage_sequencer (
    input  logic                   CLK,
    input  logic                   RESET_N,
    stage_sequencer_if.master      bus
);

    localparam logic [1:0] FETCH     = 2'b00;
    localparam logic [1:0] DECODE    = 2'b01;
    localparam logic [1:0] EXECUTE   = 2'b10;
    localparam logic [1:0] WRITEBACK = 2'b11;

    // Execute-counter preload values (execute length minus one).
    localparam logic [1:0] EXEC_SHORT = 2'd0;
    localparam logic [1:0] EXEC_LONG  = 2'd3;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_EXT = 4'b1101;

    localparam logic [2:0] SUB_MUL  = 3'b000;
    localparam logic [2:0] SUB_SR   = 3'b001;
    localparam logic [2:0] SUB_SL   = 3'b010;
    localparam logic [2:0] SUB_MULI = 3'b100;

    logic [1:0]  stage_reg;
    logic [1:0]  stage_next;
    logic [1:0]  exec_cnt_reg;
    logic [1:0]  exec_cnt_next;
    logic [15:0] instr_count_reg;
    logic [15:0] instr_count_next;
    logic        count_inc;

    logic [3:0]  opcode;
    logic [2:0]  subcode;
    logic        instr_legal;
    logic        instr_long;

    // Operand fields belong to the datapath; the sequencer never looks at them.
    logic        instr_unused;
    assign instr_unused = ^{bus.INSTRUCTION[11:6], bus.INSTRUCTION[2:0]};

    assign opcode  = bus.INSTRUCTION[15:12];
    assign subcode = bus.INSTRUCTION[5:3];

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    always_comb begin
        instr_legal = 1'b0;
        instr_long  = 1'b0;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT: instr_legal = 1'b1;
            OP_EXT: begin
                case (subcode)
                    SUB_SL, SUB_SR: instr_legal = 1'b1;
                    SUB_MUL, SUB_MULI: begin
                        instr_legal = 1'b1;
                        instr_long  = 1'b1;
                    end
                    default: instr_legal = 1'b0;
                endcase
            end
            default: instr_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        stage_next    = stage_reg;
        exec_cnt_next = exec_cnt_reg;
        case (stage_reg)
            FETCH: begin
                if (bus.MEM_READY) begin
                    stage_next = DECODE;
                end
            end
            DECODE: begin
                if (instr_legal) begin
                    exec_cnt_next = instr_long ? EXEC_LONG : EXEC_SHORT;
                    stage_next    = EXECUTE;
                end else begin
                    stage_next = FETCH;
                end
            end
            EXECUTE: begin
                if (exec_cnt_reg != 2'd0) begin
                    exec_cnt_next = exec_cnt_reg - 2'd1;
                end else begin
                    stage_next = WRITEBACK;
                end
            end
            default: begin
                stage_next = FETCH;
            end
        endcase
    end

    // The counter only moves when an instruction retires, so it is written
    // only on that enable rather than every cycle.
    assign count_inc        = (stage_reg == WRITEBACK);
    assign instr_count_next = instr_count_reg + 16'd1;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stage_reg       <= FETCH;
            exec_cnt_reg    <= 2'd0;
            instr_count_reg <= 16'd0;
        end else begin
            stage_reg    <= stage_next;
            exec_cnt_reg <= exec_cnt_next;
            if (count_inc) begin
                instr_count_reg <= instr_count_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control outputs: decodes of the registered state (plus MEM_READY in
    // FETCH). RESET_N gates them so nothing fires while reset is held,
    // even before the first reset edge has cleaned up the state.
    // ------------------------------------------------------------------
    always_comb begin
        bus.MEM_EN   = 1'b0;
        bus.MAR_LE   = 1'b0;
        bus.IR_LE    = 1'b0;
        bus.PC_LE    = 1'b0;
        bus.ALU_BUSY = 1'b0;
        bus.RD_LE    = 1'b0;
        bus.ILLEGAL  = 1'b0;
        if (RESET_N) begin
            case (stage_reg)
                FETCH: begin
                    bus.MEM_EN = 1'b1;
                    bus.MAR_LE = 1'b1;
                    bus.IR_LE  = bus.MEM_READY;
                    bus.PC_LE  = bus.MEM_READY;
                end
                DECODE: begin
                    bus.ILLEGAL = ~instr_legal;
                end
                EXECUTE: begin
                    bus.ALU_BUSY = 1'b1;
                end
                default: begin
                    bus.RD_LE = 1'b1;
                end
            endcase
        end
    end

    assign bus.STAGE       = stage_reg;
    assign bus.INSTR_COUNT = instr_count_reg;

endmodule
